bg7_render: RTL

BG7_RENDER -- requirements
Module: bg7_render

---
 rtl/bg7_render_if.sv | 22 ++
 rtl/bg7_render.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bg7_render_if.sv
// VRAM read port of the mode-7 background renderer. The renderer registers
// each word address; the memory returns the byte for it one clock later.
interface bg7_render_if;
    logic [14:0] vram_l_addr;
    logic [14:0] vram_h_addr;
    logic [7:0]  vram_rdata_l;
    logic [7:0]  vram_rdata_h;

    modport master (
        output vram_l_addr,
        output vram_h_addr,
        input  vram_rdata_l,
        input  vram_rdata_h
    );

    modport slave (
        input  vram_l_addr,
        input  vram_h_addr,
        output vram_rdata_l,
        output vram_rdata_h
    );
endinterface

// File: rtl/bg7_render.sv
// Mode-7 background renderer: one affine-transformed pixel per 8-clock dot,
// with screen-over handling, EXTBG priority split and mosaic.
module bg7_render #(
    parameter int FRAC_W    = 8,
    parameter int COORD_W   = 13,
    parameter int MAT_W     = 16,
    parameter int MOSAIC_EN = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dot_en,
    input  logic [2:0]                dot_ctr,
    input  logic                      frame_start,
    input  logic                      line_start,
    input  logic                      active,
    input  logic [7:0]                x,
    input  logic [7:0]                y,
    input  logic [7:0]                m7sel,
    input  logic signed [MAT_W-1:0]   m7_a,
    input  logic signed [MAT_W-1:0]   m7_b,
    input  logic signed [MAT_W-1:0]   m7_c,
    input  logic signed [MAT_W-1:0]   m7_d,
    input  logic signed [COORD_W-1:0] m7_xofs,
    input  logic signed [COORD_W-1:0] m7_yofs,
    input  logic signed [COORD_W-1:0] m7_xorig,
    input  logic signed [COORD_W-1:0] m7_yorig,
    input  logic [3:0]                mosaic_size,
    bg7_render_if.master              vram,
    output logic [7:0]                pix_color,
    output logic                      pix_prio,
    output logic                      pix_valid
);
    localparam int CW = COORD_W + 1;
    localparam int PW = MAT_W + CW;
    localparam int SW = PW + 2;
    localparam int TW = SW - FRAC_W;

    logic [3:0]           msize;
    logic [3:0]           row_ctr, row_nxt, col_ctr;
    logic [7:0]           my_q, my_eff, xs, ys;
    logic signed [CW-1:0] dx, dy;
    logic signed [MAT_W-1:0] k0, k1;
    logic signed [PW-1:0] prod0, prod1, pa, pb, pc, pd;
    logic signed [SW-1:0] vx, vy;
    logic signed [TW-1:0] tx, ty;
    logic                 oor, started, dot_full;
    logic [1:0]           mode;
    logic [7:0]           tile, color;
    logic                 unused_bits;

    assign msize = (MOSAIC_EN != 0) ? mosaic_size : 4'd0;
    assign mode  = m7sel[3:2];

    // While the row counter is 0 the live row is used; other rows of a mosaic
    // block reuse the row captured when the block began.
    assign my_eff = (row_ctr == 4'd0) ? y : my_q;
    assign xs     = m7sel[0] ? ~x : x;
    assign ys     = m7sel[1] ? ~my_eff : my_eff;

    // Screen coordinates are unsigned; offsets and origin are sign-extended.
    assign dx = {{(CW-8){1'b0}}, xs} + {m7_xofs[COORD_W-1], m7_xofs}
              - {m7_xorig[COORD_W-1], m7_xorig};
    assign dy = {{(CW-8){1'b0}}, ys} + {m7_yofs[COORD_W-1], m7_yofs}
              - {m7_yorig[COORD_W-1], m7_yorig};

    // Two multipliers, time-shared between the X row (phase 0) and Y row (phase 1).
    assign k0    = (dot_ctr == 3'd0) ? m7_a : m7_c;
    assign k1    = (dot_ctr == 3'd0) ? m7_b : m7_d;
    assign prod0 = PW'(k0) * PW'(dx);
    assign prod1 = PW'(k1) * PW'(dy);

    assign tx  = vx[SW-1:FRAC_W];
    assign ty  = vy[SW-1:FRAC_W];
    assign oor = (tx[TW-1:10] != '0) || (ty[TW-1:10] != '0);

    assign dot_full = dot_en && started;

    always_comb begin
        row_nxt = row_ctr;
        if (frame_start)
            row_nxt = 4'd0;
        else if (line_start)
            row_nxt = (row_ctr >= msize) ? 4'd0 : row_ctr + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pa               <= '0;
            pb               <= '0;
            pc               <= '0;
            pd               <= '0;
            vx               <= '0;
            vy               <= '0;
            tile             <= '0;
            color            <= '0;
            vram.vram_l_addr <= '0;
            vram.vram_h_addr <= '0;
            started          <= 1'b0;
            row_ctr          <= '0;
            col_ctr          <= '0;
            my_q             <= '0;
            pix_color        <= '0;
            pix_prio         <= 1'b0;
            pix_valid        <= 1'b0;
        end else begin
            case (dot_ctr)
                3'd0: begin
                    pa <= prod0;
                    pb <= prod1;
                end
                3'd1: begin
                    pc <= prod0;
                    pd <= prod1;
                end
                3'd2: begin
                    vx <= SW'(pa) + SW'(pb) + (SW'(m7_xorig) <<< FRAC_W);
                    vy <= SW'(pc) + SW'(pd) + (SW'(m7_yorig) <<< FRAC_W);
                end
                3'd3: vram.vram_l_addr <= {ty[9:3], tx[9:3]};
                3'd4: tile <= (oor && mode == 2'b11) ? 8'd0 : vram.vram_rdata_l;
                3'd5: vram.vram_h_addr <= {1'b0, tile, ty[2:0], tx[2:0]};
                3'd6: color <= (oor && mode == 2'b10) ? 8'd0 : vram.vram_rdata_h;
                default: ;
            endcase

            // A dot only counts once its phase 0 has been seen since reset.
            if (dot_ctr == 3'd0)
                started <= 1'b1;

            row_ctr <= row_nxt;
            if ((frame_start || line_start) && row_nxt == 4'd0)
                my_q <= y;

            if (line_start)
                col_ctr <= '0;
            else if (dot_full)
                col_ctr <= (col_ctr >= msize) ? 4'd0 : col_ctr + 4'd1;

            if (dot_full && col_ctr == 4'd0) begin
                if (!active) begin
                    pix_color <= '0;
                    pix_prio  <= 1'b0;
                    pix_valid <= 1'b0;
                end else begin
                    pix_valid <= 1'b1;
                    if (m7sel[4]) begin
                        pix_color <= {1'b0, color[6:0]};
                        pix_prio  <= color[7];
                    end else begin
                        pix_color <= color;
                        pix_prio  <= 1'b0;
                    end
                end
            end
        end
    end

    assign unused_bits = ^{m7sel[7:5], vx[FRAC_W-1:0], vy[FRAC_W-1:0]};
endmodule
